// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decode handshake
// and the branch-control inputs consumed at retire.
interface instr_fetch_if #(
    parameter int XLEN = 32
);
    logic            PCSrc;
    logic [XLEN-1:0] ImmExt;
    logic            instr_ready;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] Instr;
    logic            instr_valid;
    logic [31:0]     retired;
    logic            fault;

    modport master (
        input  PCSrc, ImmExt, instr_ready, imem_ack, imem_rdata,
        output imem_req, imem_addr, PC, Instr, instr_valid, retired, fault
    );

    modport slave (
        output PCSrc, ImmExt, instr_ready, imem_ack, imem_rdata,
        input  imem_req, imem_addr, PC, Instr, instr_valid, retired, fault
    );
endinterface

// File: rtl/instr_fetch.sv
// Front-end fetch unit: owns the PC, fetches one instruction at a time and
// holds it for decode until it retires, then steps or branches the PC.
module instr_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, VALID, FAULT} state_t;

    state_t          state, state_nx;
    logic [XLEN-1:0] pc_q, instr_q, target;
    logic [31:0]     ret_q;
    logic            valid_q, fault_q, retire;

    assign retire = (state == VALID) && bus.instr_ready;
    // Branch offset is two's complement; plain modular add handles negative offsets.
    assign target = pc_q + (bus.PCSrc ? bus.ImmExt : XLEN'(4));

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = FETCH;
            FETCH:   if (bus.imem_ack) state_nx = VALID;
            VALID:   if (bus.instr_ready) state_nx = (target[1:0] == 2'b00) ? FETCH : FAULT;
            FAULT:   state_nx = FAULT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            ret_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            if (state == FETCH && bus.imem_ack) begin
                instr_q <= bus.imem_rdata;
                valid_q <= 1'b1;
            end
            if (retire) begin
                pc_q    <= target;
                ret_q   <= ret_q + 32'd1;
                valid_q <= 1'b0;
                if (target[1:0] != 2'b00) fault_q <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.imem_req    = (state == FETCH);
        bus.imem_addr   = pc_q;
        bus.PC          = pc_q;
        bus.Instr       = instr_q;
        bus.instr_valid = valid_q;
        bus.retired     = ret_q;
        bus.fault       = fault_q;
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_instr_fetch;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_if #(.XLEN(32)) f ();
    instr_fetch_if #(.XLEN(32)) w ();

    instr_fetch #(.XLEN(32), .RESET_PC(32'h0))         dut   (.clk(clk), .rst(rst), .bus(f.master));
    instr_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (.clk(clk), .rst(rst), .bus(w.master));

    int n_pass = 0;
    int n_chk  = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    endtask

    // Model: "where the fetch unit is" in its life cycle of one instruction.
    // 0 = waking after reset, 1 = asking memory, 2 = holding for decode, 3 = dead on bad target.
    int          m_where;
    logic [31:0] m_pc, m_instr, m_retired;

    always @(posedge clk) begin
        if (!rst) begin
            m_where = 0; m_pc = 32'h0; m_instr = 32'h0; m_retired = 32'h0;
        end else if (m_where == 0) begin
            m_where = 1;
        end else if (m_where == 1 && f.imem_ack) begin
            m_instr = f.imem_rdata;
            m_where = 2;
        end else if (m_where == 2 && f.instr_ready) begin
            m_pc      = m_pc + (f.PCSrc ? f.ImmExt : 32'd4);
            m_retired = m_retired + 32'd1;
            m_where   = (m_pc % 4 == 0) ? 1 : 3;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m.req",     {31'b0, f.imem_req},    {31'b0, m_where == 1});
            chk("m.addr",    f.imem_addr,            m_pc);
            chk("m.pc",      f.PC,                   m_pc);
            chk("m.instr",   f.Instr,                m_instr);
            chk("m.valid",   {31'b0, f.instr_valid}, {31'b0, m_where == 2});
            chk("m.retired", f.retired,              m_retired);
            chk("m.fault",   {31'b0, f.fault},       {31'b0, m_where == 3});
        end
    end

    initial begin
        bit got;
        rst = 1'b0;
        f.PCSrc = 1'b0; f.ImmExt = '0; f.instr_ready = 1'b0; f.imem_ack = 1'b0; f.imem_rdata = '0;
        w.PCSrc = 1'b0; w.ImmExt = '0; w.instr_ready = 1'b1; w.imem_ack = 1'b1; w.imem_rdata = '0;

        // Reset state
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst.req", {31'b0, f.imem_req}, 32'd0);
        chk("rst.pc", f.PC, 32'h0);
        chk("rst.valid", {31'b0, f.instr_valid}, 32'd0);
        chk("rst.wrap_pc", w.PC, 32'hFFFF_FFFC);

        // Zero-latency memory, retire every instruction sequentially
        rst = 1'b1; f.imem_ack = 1'b1; f.instr_ready = 1'b1; f.imem_rdata = 32'h1234_5678;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            f.imem_rdata = 32'hA000_0000 + 32'(k);
            if (k % 2 == 1) begin
                chk("seq.req", {31'b0, f.imem_req}, 32'd1);
                chk("seq.addr", f.imem_addr, 32'(4 * ((k - 1) / 2)));
            end else begin
                chk("seq.req_low", {31'b0, f.imem_req}, 32'd0);
            end
            if (k == 1) chk("wrap.addr0", w.imem_addr, 32'hFFFF_FFFC);
            if (k == 3) begin
                chk("wrap.addr1", w.imem_addr, 32'h0);
                chk("wrap.fault", {31'b0, w.fault}, 32'd0);
            end
        end
        chk("seq.retired4", f.retired, 32'd4);

        // Taken backward branch from 0x10 by -8
        f.PCSrc = 1'b1; f.ImmExt = 32'hFFFF_FFF8;
        @(negedge clk);
        chk("br.pc", f.PC, 32'h10);
        @(negedge clk);
        chk("br.addr", f.imem_addr, 32'h8);
        chk("br.retired", f.retired, 32'd5);

        // Memory latency 3 cycles, then a 2-cycle decode stall with a spurious ack
        f.PCSrc = 1'b0; f.imem_ack = 1'b0; f.instr_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            chk("lat.req", {31'b0, f.imem_req}, 32'd1);
            chk("lat.addr", f.imem_addr, 32'h8);
        end
        f.imem_ack = 1'b1; f.imem_rdata = 32'hCAFE_0001;
        @(negedge clk);
        chk("lat.instr", f.Instr, 32'hCAFE_0001);
        f.imem_rdata = 32'hDEAD_0002;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("stall.instr", f.Instr, 32'hCAFE_0001);
            chk("stall.pc", f.PC, 32'h8);
        end
        f.instr_ready = 1'b1; f.imem_ack = 1'b0;
        @(negedge clk);
        chk("stall.addr", f.imem_addr, 32'hC);
        chk("stall.retired", f.retired, 32'd6);

        // Branch to 0x20, then misaligned branch to 0x26
        f.imem_ack = 1'b1; f.PCSrc = 1'b1; f.ImmExt = 32'h14;
        @(negedge clk);
        @(negedge clk);
        chk("mis.addr20", f.imem_addr, 32'h20);
        f.ImmExt = 32'h6;
        @(negedge clk);
        @(negedge clk);
        chk("mis.pc", f.PC, 32'h26);
        chk("mis.fault", {31'b0, f.fault}, 32'd1);
        chk("mis.retired", f.retired, 32'd8);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mis.req_low", {31'b0, f.imem_req}, 32'd0);
            chk("mis.sticky", {31'b0, f.fault}, 32'd1);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("mis.rst_pc", f.PC, 32'h0);
        chk("mis.rst_fault", {31'b0, f.fault}, 32'd0);
        rst = 1'b1; f.PCSrc = 1'b0;

        // Reset while a fetch is outstanding; ack during IDLE must be ignored
        repeat (6) @(negedge clk);
        f.imem_ack = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = f.imem_req;
        end
        chk("mid.fetch_seen", {31'b0, got}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid.valid", {31'b0, f.instr_valid}, 32'd0);
        chk("mid.req", {31'b0, f.imem_req}, 32'd0);
        chk("mid.retired", f.retired, 32'd0);
        rst = 1'b1; f.imem_ack = 1'b1; f.imem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        chk("mid.restart_addr", f.imem_addr, 32'h0);
        chk("mid.idle_ack_ignored", {31'b0, f.instr_valid}, 32'd0);
        @(negedge clk);
        chk("mid.fetched", f.Instr, 32'h0BAD_F00D);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] r;
            @(negedge clk);
            r = $urandom;
            rst           = ($urandom_range(99) != 0);
            f.imem_ack    = $urandom_range(1);
            f.instr_ready = $urandom_range(2) != 0;
            f.PCSrc       = $urandom_range(1);
            f.imem_rdata  = $urandom;
            f.ImmExt      = ($urandom_range(29) == 0) ? r : (r & 32'h0000_0FFC) | ((r[31]) ? 32'hFFFF_F000 : 32'h0);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
